// File: rtl/mod_reg4_4to1_if.sv
// Word-in / byte-out stream bundle for the 4-to-1 unloader.
// The ovf flag exists only when MOD_REG4_4TO1_OVF_EN is defined.
interface mod_reg4_4to1_if #(
  parameter int Nb = 4,
  parameter int W  = 8
);
  logic                 wr_en;
  logic [Nb-1:0][W-1:0] i;
  logic                 wr_rdy;
  logic [W-1:0]         o;
  logic                 o_valid;
  logic                 rd_en;
  logic                 o_last;
  logic                 busy;
`ifdef MOD_REG4_4TO1_OVF_EN
  logic                 ovf;
`endif

  modport slave (
    input  wr_en, i, rd_en,
    output wr_rdy, o, o_valid, o_last, busy
`ifdef MOD_REG4_4TO1_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output wr_en, i, rd_en,
    input  wr_rdy, o, o_valid, o_last, busy
`ifdef MOD_REG4_4TO1_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/mod_reg4_4to1.sv
// Parallel-to-serial unloader: one Nb-byte word in, Nb bytes out on a valid/ready stream.
// Optional sticky dropped-word flag: define MOD_REG4_4TO1_OVF_EN.
module mod_reg4_4to1 #(
  parameter int Nb = 4,
  parameter int W  = 8
) (
  input  logic clk,
  input  logic reset,
  mod_reg4_4to1_if.slave bus
);
  localparam int             CW   = (Nb > 1) ? $clog2(Nb) : 1;
  localparam logic [CW-1:0]  LAST = CW'(Nb - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt, w_idx;
  logic [Nb-1:0][W-1:0] r_hold;
  logic [W-1:0]         r_o, w_o_nxt;
  logic                 r_last, w_last_nxt;
  logic                 w_wr_rdy, w_load, w_xfer;

  // Accepting on the final transfer keeps the byte stream gap-free across words.
  assign w_wr_rdy = (r_state == IDLE) ||
                    ((r_state == SEND) && (r_cnt == LAST) && bus.rd_en);
  assign w_load   = bus.wr_en && w_wr_rdy;
  assign w_xfer   = (r_state == SEND) && bus.rd_en;
  assign w_idx    = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_o_nxt     = r_o;
    w_last_nxt  = r_last;
    if (w_load) begin
      w_state_nxt = SEND;
      w_cnt_nxt   = '0;
      w_o_nxt     = bus.i[0];
      w_last_nxt  = (Nb == 1);
    end else if (w_xfer) begin
      if (r_cnt != LAST) begin
        w_cnt_nxt  = w_idx;
        w_o_nxt    = r_hold[w_idx];
        w_last_nxt = (w_idx == LAST);
      end else begin
        w_state_nxt = IDLE;
        w_last_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_o     <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_o     <= w_o_nxt;
      r_last  <= w_last_nxt;
      if (w_load) r_hold <= bus.i;
    end
  end

  assign bus.wr_rdy  = w_wr_rdy;
  assign bus.o       = r_o;
  assign bus.o_valid = (r_state == SEND);
  assign bus.o_last  = r_last;
  assign bus.busy    = (r_state == SEND);

`ifdef MOD_REG4_4TO1_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (bus.wr_en && !w_wr_rdy) begin
      r_ovf <= 1'b1;
`ifndef SYNTHESIS
      $display("mod_reg4_4to1: word dropped");
`endif
    end
  end

  assign bus.ovf = r_ovf;
`endif
endmodule
